// File: rtl/data_mem_lsu.sv
// Load/store unit driving a word-organised data memory. Sub-word stores are
// done as read-modify-write; loads are sign- or zero-extended.
module data_mem_lsu #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-3:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t              state, state_nx;
  logic                we_q;
  logic [1:0]          size_q;
  logic                sgn_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   merge_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                bad_req;
  logic                mem_we_raw;
  logic [4:0]          sh;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   load_val;
  logic [DATA_W-1:0]   mask;
  logic [DATA_W-1:0]   merged;

  always_comb begin
    bad_req = 1'b0;
    case (req_size)
      2'b00:   bad_req = 1'b0;
      2'b01:   bad_req = req_addr[0];
      2'b10:   bad_req = (req_addr[1:0] != 2'b00);
      default: bad_req = 1'b1;
    endcase
  end

  // Halfwords are always even-aligned here, so one lane shift serves both sizes.
  always_comb begin
    sh       = {addr_q[1:0], 3'b000};
    shifted  = mem_rd >> sh;
    load_val = mem_rd;
    case (size_q)
      2'b00:   load_val = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
      default: load_val = mem_rd;
    endcase
    mask   = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merged = (merge_q & ~mask) | ((wdata_q << sh) & mask);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_we_raw = 1'b0;
    mem_wd     = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = bad_req ? RESP : ACCESS;
      end
      ACCESS: begin
        if (we_q && size_q != 2'b10) begin
          state_nx = WRITE;
        end else begin
          if (we_q) begin
            mem_we_raw = 1'b1;
            mem_wd     = wdata_q;
          end
          state_nx = RESP;
        end
      end
      WRITE: begin
        mem_we_raw = 1'b1;
        mem_wd     = merged;
        state_nx   = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_we    = mem_we_raw & ~rst;
  assign mem_a     = addr_q[ADDR_W-1:2];
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Response registers only change on the way into RESP so they hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (bad_req) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= load_val;
            err_q   <= 1'b0;
          end else if (size_q == 2'b10) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end else begin
            merge_q <= mem_rd;
          end
        end
        WRITE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
